// File: rtl/calib_scan_seq.sv
// Calibration-channel scanner: walks the input-mux selector through a channel range and measures each channel.
// Build macro SCAN_IRQ_EN enables the one-cycle scan-finished irq pulse; without it irq is tied low.
module calib_scan_seq #(
   parameter int DWELL  = 64,
   parameter int TMO    = 4096,
   parameter int CH_MAX = 156
) (
   input  logic        clk,
   input  logic        rst_,
   input  logic        valid_pci,
   input  logic [31:0] ad_to_tuvv,
   output logic [31:0] ad_from_tuvv,
   input  logic        rd_wr,
   input  logic        scan_sel,
   output logic        sel_cs,
   output logic        sel_valid,
   output logic [31:0] sel_data,
   input  logic        sel_active,
   output logic        meas_start,
   input  logic        meas_done,
   output logic        irq
);

   localparam logic [7:0]  CH_MAX_B   = 8'(CH_MAX);
   localparam logic [12:0] TMO_LAST   = 13'(TMO - 1);
   localparam logic [12:0] DWELL_LAST = 13'(DWELL - 1);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_BUSY,
      ST_WAIT_SETTLE,
      ST_DWELL,
      ST_MEAS,
      ST_NEXT,
      ST_OFF,
      ST_OFF_WAIT
   } state_t;

   state_t      state_q, state_d;
   logic [12:0] cnt_q, cnt_d;
   logic [7:0]  cur_ch_q, cur_ch_d;
   logic [7:0]  first_q, first_d;
   logic [7:0]  last_q, last_d;
   logic        loop_q, loop_d;
   logic        done_q, done_d;
   logic        err_rng_q, err_rng_d;
   logic        err_tmo_q, err_tmo_d;
   logic        ok_q, ok_d;

   logic        wr_en, start_w, abort_w, range_ok, tmo_hit, abortable, busy;
   logic [7:0]  wr_first, wr_last;
   logic        unused_ad;

   assign wr_en    = scan_sel & valid_pci & rd_wr;
   assign wr_first = ad_to_tuvv[7:0];
   assign wr_last  = ad_to_tuvv[15:8];
   // abort beats start when both arrive in one write
   assign start_w  = wr_en & ad_to_tuvv[16] & ~ad_to_tuvv[18];
   assign abort_w  = wr_en & ad_to_tuvv[18];
   assign range_ok = (wr_first <= wr_last) && (wr_last <= CH_MAX_B);
   assign tmo_hit  = (cnt_q == TMO_LAST);
   assign unused_ad = ^ad_to_tuvv[31:19];

   assign busy      = (state_q != ST_IDLE);
   assign abortable = busy && (state_q != ST_OFF) && (state_q != ST_OFF_WAIT);

   assign sel_cs     = (state_q == ST_ISSUE) || (state_q == ST_OFF);
   assign sel_valid  = sel_cs;
   assign sel_data   = (state_q == ST_ISSUE) ? {23'b0, 1'b1, cur_ch_q} : 32'b0;
   // Fires in the last dwell cycle, so it lands DWELL cycles after sel_active drops
   assign meas_start = (state_q == ST_DWELL) && (cnt_q == DWELL_LAST);

   assign ad_from_tuvv = (scan_sel && !rd_wr) ?
                         {20'b0, err_tmo_q, err_rng_q, busy, done_q, cur_ch_q} : 32'bz;

`ifdef SCAN_IRQ_EN
   logic irq_q, irq_d;
   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = 13'd0;
      cur_ch_d  = cur_ch_q;
      first_d   = first_q;
      last_d    = last_q;
      loop_d    = loop_q;
      done_d    = done_q;
      err_rng_d = err_rng_q;
      err_tmo_d = err_tmo_q;
      ok_d      = ok_q;
`ifdef SCAN_IRQ_EN
      irq_d     = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start_w) begin
               if (range_ok) begin
                  first_d   = wr_first;
                  last_d    = wr_last;
                  loop_d    = ad_to_tuvv[17];
                  cur_ch_d  = wr_first;
                  done_d    = 1'b0;
                  err_rng_d = 1'b0;
                  err_tmo_d = 1'b0;
                  ok_d      = 1'b0;
                  state_d   = ST_ISSUE;
               end else begin
                  err_rng_d = 1'b1;
               end
            end
         end
         ST_ISSUE: state_d = ST_WAIT_BUSY;
         ST_WAIT_BUSY: begin
            if (sel_active) begin
               state_d = ST_WAIT_SETTLE;
            end else if (tmo_hit) begin
               err_tmo_d = 1'b1;
               state_d   = ST_OFF;
            end
         end
         ST_WAIT_SETTLE: begin
            if (!sel_active) begin
               state_d = ST_DWELL;
            end else if (tmo_hit) begin
               err_tmo_d = 1'b1;
               state_d   = ST_OFF;
            end
         end
         ST_DWELL: begin
            if (cnt_q == DWELL_LAST) state_d = ST_MEAS;
         end
         ST_MEAS: begin
            if (meas_done) begin
               state_d = ST_NEXT;
            end else if (tmo_hit) begin
               err_tmo_d = 1'b1;
               state_d   = ST_OFF;
            end
         end
         ST_NEXT: begin
            if (cur_ch_q != last_q) begin
               cur_ch_d = cur_ch_q + 8'd1;
               state_d  = ST_ISSUE;
            end else if (loop_q) begin
               cur_ch_d = first_q;
               state_d  = ST_ISSUE;
            end else begin
               ok_d    = 1'b1;
               state_d = ST_OFF;
            end
         end
         ST_OFF: state_d = ST_OFF_WAIT;
         ST_OFF_WAIT: begin
            if (!sel_active) begin
               // only a scan that ran to its last channel counts as done
               done_d  = ok_q;
`ifdef SCAN_IRQ_EN
               irq_d   = ok_q;
`endif
               ok_d    = 1'b0;
               state_d = ST_IDLE;
            end else if (tmo_hit) begin
               err_tmo_d = 1'b1;
               ok_d      = 1'b0;
               state_d   = ST_OFF;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (abort_w && abortable) begin
         state_d  = ST_OFF;
         cur_ch_d = cur_ch_q;
         ok_d     = 1'b0;
      end

      // shared wait/dwell counter restarts on every state entry
      if ((state_d == state_q) && (state_q != ST_IDLE)) cnt_d = cnt_q + 13'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 13'd0;
         cur_ch_q  <= 8'd0;
         first_q   <= 8'd0;
         last_q    <= 8'd0;
         loop_q    <= 1'b0;
         done_q    <= 1'b0;
         err_rng_q <= 1'b0;
         err_tmo_q <= 1'b0;
         ok_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cur_ch_q  <= cur_ch_d;
         first_q   <= first_d;
         last_q    <= last_d;
         loop_q    <= loop_d;
         done_q    <= done_d;
         err_rng_q <= err_rng_d;
         err_tmo_q <= err_tmo_d;
         ok_q      <= ok_d;
      end
   end

`ifdef SCAN_IRQ_EN
   always_ff @(posedge clk) begin
      if (!rst_) irq_q <= 1'b0;
      else       irq_q <= irq_d;
   end
`endif

endmodule
